// File: rtl/pwm_pkg.sv
// Shared constants and types for the dual-channel PWM motor driver.
// The PWM_DEADTIME_EN build macro enables the per-channel BRAKE state.
package pwm_pkg;

    localparam int PERIOD_DEF     = 100;
    localparam int DUTY_W_DEF     = 7;
    localparam int DEAD_TICKS_DEF = 4;
    localparam int CNT_W_DEF      = $clog2(PERIOD_DEF);

    typedef enum logic {
        RUN   = 1'b0,
        BRAKE = 1'b1
    } chan_state_t;

    // Counter width for a given period, never narrower than one bit.
    function automatic int cnt_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/pwm_motor_driver_if.sv
// Command handshake bundle between the SoC and the PWM motor driver.
// The PWM_DEADTIME_EN build macro does not change this interface.
interface pwm_motor_driver_if
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty_a;
    logic [DUTY_W-1:0] cmd_duty_b;
    logic              cmd_dir_a;
    logic              cmd_dir_b;

    modport master (
        output cmd_valid, cmd_duty_a, cmd_duty_b, cmd_dir_a, cmd_dir_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_duty_a, cmd_duty_b, cmd_dir_a, cmd_dir_b,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: active duty/direction registers and the compare.
// With PWM_DEADTIME_EN defined, a RUN/BRAKE state machine holds the output
// low and keeps the old direction for DEAD_TICKS ticks on a reversal.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DEAD_TICKS = DEAD_TICKS_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PWM_DEADTIME_EN
    input  logic              tick,
`endif
    input  logic [CNT_W-1:0]  cnt,
    input  logic              load,
    input  logic [DUTY_W-1:0] duty_new,
    input  logic              dir_new,
    output logic              pwm,
    output logic              dir
);

    logic [DUTY_W-1:0] duty;

    // Unsigned compare with both operands zero-extended to a common width,
    // so a duty at or above the period keeps the output high all period.
    function automatic logic duty_cmp(input logic [CNT_W-1:0] c,
                                      input logic [DUTY_W-1:0] d);
        return (32'(c) < 32'(d));
    endfunction

`ifdef PWM_DEADTIME_EN

    localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

    chan_state_t       state;
    logic [DEAD_W-1:0] dead_cnt;
    logic              dir_target;

    // Compare plus brake FSM; the commit tick itself does not count as a brake tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            duty       <= '0;
            dir        <= 1'b0;
            dir_target <= 1'b0;
            dead_cnt   <= '0;
            pwm        <= 1'b0;
        end else begin
            pwm <= (state == RUN) && duty_cmp(cnt, duty);
            case (state)
                RUN: begin
                    if (load) begin
                        duty <= duty_new;
                        if (dir_new != dir) begin
                            state      <= BRAKE;
                            dir_target <= dir_new;
                            dead_cnt   <= '0;
                        end
                    end
                end
                BRAKE: begin
                    if (load) begin
                        duty <= duty_new;
                    end
                    if (load && (dir_new == dir)) begin
                        // Reversal withdrawn before the brake finished.
                        state <= RUN;
                    end else if (tick) begin
                        if (dead_cnt == DEAD_W'(DEAD_TICKS - 1)) begin
                            dir   <= dir_target;
                            state <= RUN;
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`else

    // Compare, with duty and direction both taken at the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty <= '0;
            dir  <= 1'b0;
            pwm  <= 1'b0;
        end else begin
            pwm <= duty_cmp(cnt, duty);
            if (load) begin
                duty <= duty_new;
                dir  <= dir_new;
            end
        end
    end

`endif

endmodule

// File: rtl/pwm_motor_driver.sv
// Dual-channel PWM motor driver top: synchroniser and tick generation for
// the divided clock, the shared period counter and command staging.
// Build macro PWM_DEADTIME_EN adds a dead-time brake on direction reversal.
module pwm_motor_driver
    import pwm_pkg::*;
#(
    parameter int PERIOD     = PERIOD_DEF,
    parameter int DUTY_W     = DUTY_W_DEF,
    parameter int DEAD_TICKS = DEAD_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_clk_in,
    pwm_motor_driver_if.slave  cmd,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic               dir_a,
    output logic               dir_b,
    output logic               period_start
);

    localparam int               CNT_W   = cnt_width(PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    localparam bit               CFG_OK  = (2 ** DUTY_W > PERIOD) && (DEAD_TICKS >= 1);

    if (!CFG_OK) begin : g_cfg_check
        $error("pwm_motor_driver: requires 2**DUTY_W > PERIOD and DEAD_TICKS >= 1");
    end

    logic              s1, s2, s3;
    logic              tick;
    logic              tick_d;
    logic [CNT_W-1:0]  cnt;
    logic              wrap;
    logic              pending;
    logic              accept;
    logic              load;
    logic [DUTY_W-1:0] stage_duty_a, stage_duty_b;
    logic              stage_dir_a, stage_dir_b;

    assign wrap          = tick && (cnt == CNT_MAX);
    assign accept        = cmd.cmd_valid && !pending;
    assign load          = wrap && pending;
    assign cmd.cmd_ready = !pending;

    // Synchronise the divided clock and register its rising edge as a one-cycle tick;
    // flops start high so an initially-high divider gives no tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s3   <= 1'b1;
            tick <= 1'b0;
        end else begin
            s1   <= pwm_clk_in;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end

    // Period counter; period_start marks the cycle after the wrap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            tick_d       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            tick_d       <= tick;
            period_start <= tick_d && (cnt == '0);
            if (tick) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            end
        end
    end

    // Pending flag: set on accept, cleared when the staged command commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (load) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end
    end

    // Staging data needs no reset: it is only used while pending is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            stage_duty_a <= cmd.cmd_duty_a;
            stage_duty_b <= cmd.cmd_duty_b;
            stage_dir_a  <= cmd.cmd_dir_a;
            stage_dir_b  <= cmd.cmd_dir_b;
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_channel #(
        .DUTY_W     (DUTY_W),
        .CNT_W      (CNT_W),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_chan_a (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .cnt      (cnt),
        .load     (load),
        .duty_new (stage_duty_a),
        .dir_new  (stage_dir_a),
        .pwm      (pwm_a),
        .dir      (dir_a)
    );

    pwm_channel #(
        .DUTY_W     (DUTY_W),
        .CNT_W      (CNT_W),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_chan_b (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .cnt      (cnt),
        .load     (load),
        .duty_new (stage_duty_b),
        .dir_new  (stage_dir_b),
        .pwm      (pwm_b),
        .dir      (dir_b)
    );
`else
    pwm_channel #(
        .DUTY_W (DUTY_W),
        .CNT_W  (CNT_W)
    ) u_chan_a (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .load     (load),
        .duty_new (stage_duty_a),
        .dir_new  (stage_dir_a),
        .pwm      (pwm_a),
        .dir      (dir_a)
    );

    pwm_channel #(
        .DUTY_W (DUTY_W),
        .CNT_W  (CNT_W)
    ) u_chan_b (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .load     (load),
        .duty_new (stage_duty_b),
        .dir_new  (stage_dir_b),
        .pwm      (pwm_b),
        .dir      (dir_b)
    );
`endif

endmodule

// File: doc/pwm_motor_driver.md
# pwm_motor_driver

Dual-channel PWM generator for the robot's two drive motors, sitting directly downstream of the 20 kHz divided-clock stage. Each rising edge of the divided clock is one PWM tick. Duty and direction commands arrive from the SoC over a valid/ready handshake and take effect only at period boundaries, so every output pulse is complete. An optional dead-time stage protects the H-bridge when a channel reverses direction.

## Interface
- `PERIOD`, default 100: ticks per PWM period. With a 20 kHz tick this gives 200 Hz, and duty is a percentage.
- `DUTY_W`, default 7: width of the duty fields. Must satisfy 2^DUTY_W > PERIOD.
- `DEAD_TICKS`, default 4: brake length in ticks on a direction reversal.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `pwm_clk_in` in 1: divided clock from the upstream divider; asynchronous to `clk` as far as this block is concerned.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_duty_a`, `cmd_duty_b` in DUTY_W: requested duty per channel.
- `cmd_dir_a`, `cmd_dir_b` in 1: requested direction per channel.
- `pwm_a`, `pwm_b` out 1: PWM outputs to the motor drivers.
- `dir_a`, `dir_b` out 1: direction outputs to the motor drivers.
- `period_start` out 1: one-`clk` pulse at each counter wrap.

## Operation
- **Tick generation:** `pwm_clk_in` passes through a 2-flop synchroniser (s1, s2), then a registered rising-edge detector (s3). `tick = s2 & ~s3`, registered. All three flops reset to 1, so the divider's initial-high level never produces a spurious tick.
- **Counter:** `cnt` runs 0..PERIOD-1 and advances only on a tick. A tick at PERIOD-1 wraps it to 0. That wrap is the commit point.
- **Command staging:**
  - `cmd_ready = ~pending`.
  - On accept, duties and directions are latched into staging registers and `pending` is set.
  - At the commit point, staging is copied to the active registers and `pending` clears.
  - A command accepted in the same cycle as a commit waits for the next wrap.
- **PWM compare:** `pwm_x <= (cnt < duty_active_x)`, registered.
  - duty 0 gives constant low.
  - duty ≥ PERIOD gives constant high for the whole period.
  - Arithmetic is unsigned; duty is zero-extended to the counter width.
- **Per-channel state machine** (macro enabled only):
  - RUN: normal compare.
  - On a commit whose direction differs from `dir_x`: go to BRAKE.
  - BRAKE: `pwm_x` is forced 0 and `dir_x` holds the old value for DEAD_TICKS ticks. On the last tick, `dir_x` takes the new direction and the state returns to RUN; compare resumes from the next tick.
  - A commit during BRAKE updates the duty immediately. The target direction is re-evaluated: if it now equals `dir_x`, return to RUN at once. Otherwise the brake count continues.
- **Reset mid-operation:** everything returns to its reset value asynchronously. Any staged command is discarded.
- **Reset values:** `pwm_x` 0, `dir_x` 0, `period_start` 0, `cmd_ready` 1, `cnt` 0, active duties 0, state RUN.
- **Stalled input:** if `pwm_clk_in` stops toggling, `cnt` and all outputs hold their current values.

## Timing
- E0 is the first `clk` edge that samples `pwm_clk_in = 1`.
- `tick` is high for exactly one cycle, following edge E2.
- `cnt` updates at E3.
- `pwm_x` and `period_start` update at E4.
- Commit occurs at E3 of the wrap tick. The new duty is visible on `pwm_x` from E4.
- `cmd_ready` drops the cycle after accept and rises the cycle after commit.
- Minimum `pwm_clk_in` high and low time is 3 `clk` cycles; this is always met from the divider.

## Configuration
- `PWM_DEADTIME_EN` defined: the BRAKE state and its DEAD_TICKS counter are built.
- `PWM_DEADTIME_EN` undefined: no brake state; `dir_x` updates directly at commit, at the same edge as the duty.

## Structure
- Package `pwm_pkg` holds:
  - default PERIOD, DUTY_W and DEAD_TICKS constants;
  - the channel state enum {RUN, BRAKE};
  - the counter-width constant `$clog2(PERIOD)`.
- Sub-module `pwm_channel` holds the active duty and direction registers, the compare and the brake FSM. It is instantiated twice.
- The top level holds the synchroniser, tick generation, counter, and command staging.

## Test plan
- Reset with `pwm_clk_in` held at 1 → no tick; `pwm_x`, `dir_x` 0; `cmd_ready` 1.
- Command duty_a=25, duty_b=100, both directions 0 → after the next wrap, `pwm_a` is high for 25 of 100 ticks and `pwm_b` is high for the entire period.
- duty_a=0 → `pwm_a` stays low for every cycle of the period; `period_start` pulses once per 100 ticks.
- Second command while pending → `cmd_ready` is 0 and the command is not taken; it is accepted the cycle after commit and applied at the following wrap.
- Macro defined, channel A at duty 50 / dir 0, commit dir 1:
  - `pwm_a` is low for 4 ticks;
  - `dir_a` flips on the 4th tick;
  - PWM resumes at 50.
- Same scenario without the macro → `dir_a` flips at E3 of the wrap tick. Then assert `rst` mid-period → all outputs drop to 0 immediately and `cnt` is 0.
